// File: rtl/uart_transmitter.sv
// Tick-paced UART transmitter with a one-entry holding register in front of the frame shifter.
// Frame: start, DATA_BITS LSB first, optional parity, 1 or 2 stop bits; back-to-back frames have no idle gap.
module uart_transmitter #(
  parameter int DATA_BITS = 8,
  parameter int PARITY    = 0,
  parameter int STOP_BITS = 1
) (
  input  logic                 Clk,
  input  logic                 Reset,
  input  logic                 Tick,
  input  logic [DATA_BITS-1:0] DataIn,
  input  logic                 DataValid,
  output logic                 DataReady,
  output logic                 Tx,
  output logic                 Busy
);

  generate
    if (DATA_BITS < 5 || DATA_BITS > 9) begin : g_bad_data_bits
      $error("uart_transmitter: DATA_BITS must be 5..9");
    end
    if (PARITY < 0 || PARITY > 2) begin : g_bad_parity
      $error("uart_transmitter: PARITY must be 0, 1 or 2");
    end
    if (STOP_BITS != 1 && STOP_BITS != 2) begin : g_bad_stop_bits
      $error("uart_transmitter: STOP_BITS must be 1 or 2");
    end
  endgenerate

  localparam int                IDX_W     = $clog2(DATA_BITS);
  localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(DATA_BITS - 1);
  localparam logic             LAST_STOP = (STOP_BITS == 2);

  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_t;

  state_t               state, state_nxt;
  logic [DATA_BITS-1:0] hold, shifter, shifter_nxt;
  logic                 hold_full, hold_full_nxt;
  logic [IDX_W-1:0]     bit_idx, bit_idx_nxt;
  logic                 stop_cnt, stop_cnt_nxt;
  logic                 par_bit, par_nxt;
  logic                 tx_q, tx_nxt;
  logic                 accept, load, load_par;

  assign accept    = DataValid && !hold_full;
  assign load_par  = (PARITY == 2) ? ^hold : ~^hold;
  assign DataReady = !hold_full;
  assign Busy      = (state != S_IDLE);
  assign Tx        = tx_q;

  always_comb begin
    state_nxt    = state;
    shifter_nxt  = shifter;
    bit_idx_nxt  = bit_idx;
    stop_cnt_nxt = stop_cnt;
    par_nxt      = par_bit;
    load         = 1'b0;
    if (Tick) begin
      case (state)
        S_IDLE:   load = hold_full;
        S_START: begin
          state_nxt   = S_DATA;
          bit_idx_nxt = '0;
        end
        S_DATA: begin
          shifter_nxt = shifter >> 1;
          if (bit_idx == LAST_IDX) begin
            state_nxt    = (PARITY != 0) ? S_PARITY : S_STOP;
            stop_cnt_nxt = 1'b0;
          end else begin
            bit_idx_nxt = bit_idx + IDX_W'(1);
          end
        end
        S_PARITY: begin
          state_nxt    = S_STOP;
          stop_cnt_nxt = 1'b0;
        end
        S_STOP: begin
          if (stop_cnt == LAST_STOP) begin
            if (hold_full) load = 1'b1;
            else           state_nxt = S_IDLE;
          end else begin
            stop_cnt_nxt = 1'b1;
          end
        end
        default:  state_nxt = S_IDLE;
      endcase
    end
    // A load only happens with hold_full set, so it never races an accept.
    if (load) begin
      state_nxt   = S_START;
      shifter_nxt = hold;
      par_nxt     = load_par;
    end
    hold_full_nxt = load ? 1'b0 : (accept ? 1'b1 : hold_full);
    // Tx is registered from the next state so it lands on the same edge as the state change.
    case (state_nxt)
      S_START:  tx_nxt = 1'b0;
      S_DATA:   tx_nxt = shifter_nxt[0];
      S_PARITY: tx_nxt = par_nxt;
      default:  tx_nxt = 1'b1;
    endcase
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state     <= S_IDLE;
      hold      <= '0;
      hold_full <= 1'b0;
      shifter   <= '0;
      bit_idx   <= '0;
      stop_cnt  <= 1'b0;
      par_bit   <= 1'b0;
      tx_q      <= 1'b1;
    end else begin
      state     <= state_nxt;
      hold_full <= hold_full_nxt;
      shifter   <= shifter_nxt;
      bit_idx   <= bit_idx_nxt;
      stop_cnt  <= stop_cnt_nxt;
      par_bit   <= par_nxt;
      tx_q      <= tx_nxt;
      if (accept) hold <= DataIn;
    end
  end

endmodule

// File: tb/tb_uart_transmitter.sv
// Bench for uart_transmitter: four configurations side by side, each checked every cycle against a
// bit-queue line model, plus directed frame checks and a randomized word scoreboard.
module tb_uart_transmitter;

  function automatic int cfg_db(int k); return (k == 3) ? 5 : 8; endfunction
  function automatic int cfg_pa(int k); return (k == 1) ? 2 : (k == 2) ? 1 : 0; endfunction
  function automatic int cfg_sb(int k); return (k == 3) ? 2 : 1; endfunction
  function automatic int flen(int k);
    return 1 + cfg_db(k) + ((cfg_pa(k) != 0) ? 1 : 0) + cfg_sb(k);
  endfunction

  // Whole frame as the line should show it, bit 0 first; bits above the frame are idle ones.
  function automatic logic [15:0] frame(int k, logic [8:0] w);
    logic [15:0] f = '1;
    logic p = 1'b0;
    f[0] = 1'b0;
    for (int i = 0; i < cfg_db(k); i++) begin
      f[i+1] = w[i];
      p      = p ^ w[i];
    end
    if (cfg_pa(k) != 0) f[cfg_db(k)+1] = (cfg_pa(k) == 2) ? p : !p;
    return f;
  endfunction

  logic       Clk = 1'b0;
  logic       Reset, Tick;
  logic [8:0] din [4];
  logic [3:0] dvld, rdy, tx, busy;

  always #5 Clk = ~Clk;

  for (genvar g = 0; g < 4; g++) begin : g_dut
    localparam int W = cfg_db(g);
    uart_transmitter #(.DATA_BITS(W), .PARITY(cfg_pa(g)), .STOP_BITS(cfg_sb(g))) u_dut (
      .Clk(Clk), .Reset(Reset), .Tick(Tick), .DataIn(din[g][W-1:0]), .DataValid(dvld[g]),
      .DataReady(rdy[g]), .Tx(tx[g]), .Busy(busy[g]));
  end

  // Line model: fr holds the bits still to appear on the line (fr[0] is showing), fn how many.
  typedef struct packed {
    logic [15:0] fr;
    logic [4:0]  fn;
    logic        hv;
    logic [8:0]  hd;
  } mstate_t;

  mstate_t ms [4];

  function automatic mstate_t mstep(int k, mstate_t s, logic tk, logic v, logic [8:0] d);
    mstate_t r = s;
    if (tk) begin
      if (r.fn != 0) begin
        r.fr = r.fr >> 1;
        r.fn = r.fn - 5'd1;
      end
      if (r.fn == 0 && s.hv) begin
        r.fr = frame(k, s.hd);
        r.fn = 5'(flen(k));
        r.hv = 1'b0;
      end
    end
    if (v && !s.hv) begin
      r.hv = 1'b1;
      r.hd = d;
    end
    return r;
  endfunction

  always @(posedge Clk or posedge Reset) begin
    for (int k = 0; k < 4; k++) begin
      if (Reset) ms[k] <= '{fr: '1, fn: '0, hv: 1'b0, hd: '0};
      else       ms[k] <= mstep(k, ms[k], Tick, dvld[k], din[k]);
    end
  end

  int          total = 0, bad = 0;
  logic [31:0] lg [4];
  int          nl [4], bc [4];
  int          ph = 0, acc_cnt = 0;
  bit          rx_on = 1'b0;
  logic [8:0]  sb [4][$];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic clr();
    for (int k = 0; k < 4; k++) begin
      lg[k] = '0;
      nl[k] = 0;
      bc[k] = 0;
    end
  endtask

  // One clock: apply Tick, log frame bits, decode frames when enabled, and compare with the model.
  task automatic step(input logic tk);
    for (int k = 0; k < 4; k++)
      if (rx_on && dvld[k] && !ms[k].hv) begin
        sb[k].push_back(din[k] & 9'((1 << cfg_db(k)) - 1));
        acc_cnt++;
      end
    Tick = tk;
    @(posedge Clk);
    @(negedge Clk);
    for (int k = 0; k < 4; k++) begin
      if (tk && busy[k]) begin
        lg[k][nl[k]] = tx[k];
        nl[k]++;
      end
      if (busy[k]) bc[k]++;
      if (rx_on && nl[k] == flen(k)) begin
        logic [31:0] m = (32'd1 << flen(k)) - 32'd1;
        logic [31:0] e = '0;
        if (sb[k].size() != 0) e = 32'(frame(k, sb[k].pop_front())) & m;
        chk($sformatf("rx%0d", k), lg[k] & m, e);
        lg[k] = '0;
        nl[k] = 0;
      end
      chk($sformatf("tx%0d", k), 32'(tx[k]), 32'((ms[k].fn != 0) ? ms[k].fr[0] : 1'b1));
      chk($sformatf("busy%0d", k), 32'(busy[k]), 32'(ms[k].fn != 0));
      chk($sformatf("rdy%0d", k), 32'(rdy[k]), 32'(!ms[k].hv));
    end
  endtask

  task automatic runstep();
    logic tk = (ph == 3);
    ph = (ph + 1) % 4;
    step(tk);
  endtask

  task automatic offer(input logic [3:0] mask);
    logic [3:0] acc;
    int n = 0;
    dvld = mask;
    while (dvld != 0 && n < 100) begin
      acc = dvld & rdy;
      runstep();
      dvld = dvld & ~acc;
      n++;
    end
    if (dvld != 0) chk("offer_timeout", 32'(dvld), 32'd0);
    dvld = '0;
  endtask

  task automatic wait_busy(input int k);
    int n = 0;
    while (!busy[k] && n < 40) begin
      runstep();
      n++;
    end
    chk("wait_busy", 32'(busy[k]), 32'd1);
  endtask

  function automatic bit model_idle();
    for (int k = 0; k < 4; k++) if (ms[k].fn != 0 || ms[k].hv) return 1'b0;
    return 1'b1;
  endfunction

  initial begin
    int n_acc, cyc;
    logic tk, last_tk;
    Reset = 1'b1;
    Tick  = 1'b0;
    dvld  = '0;
    for (int k = 0; k < 4; k++) din[k] = '0;
    clr();
    @(negedge Clk);
    for (int k = 0; k < 4; k++) begin
      chk("rst_tx", 32'(tx[k]), 32'd1);
      chk("rst_busy", 32'(busy[k]), 32'd0);
      chk("rst_rdy", 32'(rdy[k]), 32'd1);
    end
    Reset = 1'b0;

    // Single frames on every configuration at once.
    din[0] = 9'h55; din[1] = 9'hA5; din[2] = 9'hA5; din[3] = 9'b10011;
    offer(4'hF);
    repeat (70) runstep();
    chk("basic_seq", lg[0], 32'b1010101010);
    chk("basic_len", 32'(nl[0]), 32'd10);
    chk("basic_busy", 32'(bc[0]), 32'd40);
    chk("even_seq", lg[1], 32'h54A);
    chk("even_len", 32'(nl[1]), 32'd11);
    chk("odd_seq", lg[2], 32'h74A);
    chk("odd_len", 32'(nl[2]), 32'd11);
    chk("w5s2_seq", lg[3], 32'hE6);
    chk("w5s2_len", 32'(nl[3]), 32'd8);

    // Back-to-back: second word offered while the first is in its start bit.
    clr();
    din[0] = 9'hA5;
    offer(4'b0001);
    wait_busy(0);
    din[0] = 9'h3C;
    offer(4'b0001);
    chk("b2b_rdy_low", 32'(rdy[0]), 32'd0);
    repeat (100) runstep();
    chk("b2b_seq", lg[0], 32'({1'b1, 8'h3C, 1'b0, 1'b1, 8'hA5, 1'b0}));
    chk("b2b_len", 32'(nl[0]), 32'd20);
    chk("b2b_busy", 32'(bc[0]), 32'd80);

    // Accept on the same edge as a Tick in IDLE: start waits for the next Tick.
    while (ph != 3) runstep();
    din[0]  = 9'h81;
    dvld[0] = 1'b1;
    runstep();
    dvld[0] = 1'b0;
    chk("coinc_busy0", 32'(busy[0]), 32'd0);
    chk("coinc_rdy", 32'(rdy[0]), 32'd0);
    repeat (3) runstep();
    chk("coinc_busy3", 32'(busy[0]), 32'd0);
    runstep();
    chk("coinc_busy4", 32'(busy[0]), 32'd1);
    chk("coinc_tx4", 32'(tx[0]), 32'd0);
    repeat (60) runstep();

    // DataValid held high: only one accept per emptying of the holding register.
    clr();
    din[0]  = 9'h42;
    dvld[0] = 1'b1;
    n_acc   = 0;
    repeat (60) begin
      if (rdy[0]) n_acc++;
      runstep();
    end
    dvld[0] = 1'b0;
    chk("held_accepts", 32'(n_acc), 32'd3);
    repeat (80) runstep();
    chk("held_seq", lg[0] & 32'h3FFF_FFFF, 32'({3{10'h284}}));
    chk("held_len", 32'(nl[0]), 32'd30);

    // Asynchronous reset during data bit 3, with a second word waiting in the holding register.
    din[0] = 9'hFF;
    offer(4'b0001);
    wait_busy(0);
    din[0] = 9'h77;
    offer(4'b0001);
    while (ph != 0) runstep();
    repeat (12) runstep();
    #2 Reset = 1'b1;
    #1;
    chk("mid_rst_tx", 32'(tx[0]), 32'd1);
    chk("mid_rst_busy", 32'(busy[0]), 32'd0);
    chk("mid_rst_rdy", 32'(rdy[0]), 32'd1);
    @(negedge Clk);
    Reset = 1'b0;
    clr();
    din[0] = 9'h0F;
    offer(4'b0001);
    repeat (60) runstep();
    chk("post_rst_seq", lg[0], 32'h21E);
    chk("post_rst_len", 32'(nl[0]), 32'd10);

    // Random words, random single-cycle ticks, every frame decoded against the scoreboard.
    clr();
    rx_on   = 1'b1;
    last_tk = 1'b0;
    cyc     = 0;
    while (acc_cnt < 1000 && cyc < 60000) begin
      for (int k = 0; k < 4; k++) begin
        dvld[k] = 1'($urandom_range(0, 1));
        din[k]  = 9'($urandom);
      end
      tk      = !last_tk && ($urandom_range(0, 2) == 0);
      last_tk = tk;
      step(tk);
      cyc++;
    end
    chk("rand_words", 32'(acc_cnt >= 1000), 32'd1);
    dvld = '0;
    cyc  = 0;
    while (!model_idle() && cyc < 3000) begin
      tk      = !last_tk && ($urandom_range(0, 2) == 0);
      last_tk = tk;
      step(tk);
      cyc++;
    end
    repeat (4) step(1'b0);
    for (int k = 0; k < 4; k++) begin
      chk($sformatf("sb_left%0d", k), 32'(sb[k].size()), 32'd0);
      chk($sformatf("idle_busy%0d", k), 32'(busy[k]), 32'd0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
